// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (serial double dabble) driving DIGITS seven-segment
// displays. Ports: clk, rst_n, en, load, value -> busy, done, bcd, seg.
module bcd_display_driver #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 2,
    parameter int LZB    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    function automatic int unsigned max_value(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'b0000001;
            4'd1:    r = 7'b1001111;
            4'd2:    r = 7'b0010010;
            4'd3:    r = 7'b0000110;
            4'd4:    r = 7'b1001100;
            4'd5:    r = 7'b0100100;
            4'd6:    r = 7'b0100000;
            4'd7:    r = 7'b0001111;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0000100;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam int          CW   = $clog2(WIDTH + 1);
    localparam int unsigned MAXV = max_value(DIGITS);

    logic [1:0]          state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] scr_q, scr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                done_q, done_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic [4*DIGITS-1:0] adj;
    logic                lead;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        adj     = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = value;
                    scr_d   = '0;
                    cnt_d   = '0;
                    // Out-of-range inputs are flagged now and
                    // replaced by all nines at commit time.
                    sat_d   = 32'(value) > MAXV;
                    state_d = CONV;
                end
            end
            CONV: begin
                scr_d   = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                bcd_d   = sat_q ? {DIGITS{4'h9}} : scr_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Blanking walks down from the top digit; the first nonzero
    // digit (or digit 0) ends the leading-zero run.
    always_comb begin
        seg_d = '1;
        lead  = (LZB != 0);
        if (en) begin
            for (int k = DIGITS - 1; k >= 0; k--) begin
                if (lead && k != 0 && bcd_q[4*k +: 4] == 4'd0) begin
                    seg_d[7*k +: 7] = 7'b1111111;
                end else begin
                    lead = 1'b0;
                    seg_d[7*k +: 7] = enc(bcd_q[4*k +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: instance A (7 bits, 2 digits)
// and instance B (10 bits, 3 digits, leading-zero blanking).
module tb_bcd_display_driver;

    localparam logic [6:0] ENC [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef struct {
        int     v;
        longint t;
    } exp_t;

    logic        clk, rst_n;
    logic        en_a, load_a, busy_a, done_a;
    logic [6:0]  value_a;
    logic [7:0]  bcd_a;
    logic [13:0] seg_a;
    logic        en_b, load_b, busy_b, done_b;
    logic [9:0]  value_b;
    logic [11:0] bcd_b;
    logic [20:0] seg_b;

    exp_t   qa[$];
    exp_t   qb[$];
    longint cyc;
    longint nok [2];
    int     cur [2];
    int     brun [2];
    int     checks, errors;

    bcd_display_driver #(.WIDTH(7), .DIGITS(2), .LZB(0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a),
        .value(value_a), .busy(busy_a), .done(done_a),
        .bcd(bcd_a), .seg(seg_a)
    );

    bcd_display_driver #(.WIDTH(10), .DIGITS(3), .LZB(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .load(load_b),
        .value(value_b), .busy(busy_b), .done(done_b),
        .bcd(bcd_b), .seg(seg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v, input int d);
        int m;
        m = 1;
        for (int k = 0; k < d; k++) m = m * 10;
        return (v > m - 1) ? m - 1 : v;
    endfunction

    function automatic logic [63:0] mbcd(input int v, input int d);
        logic [63:0] r;
        r = '0;
        v = sat(v, d);
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] mseg(input int v, input int d,
                                         input int lzb, input logic e);
        logic [63:0] r;
        int p;
        r = '0;
        p = 1;
        v = sat(v, d);
        for (int k = 0; k < d; k++) begin
            if (!e || (lzb != 0 && k > 0 && v < p))
                r[7*k +: 7] = 7'b1111111;
            else
                r[7*k +: 7] = ENC[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int i);
        exp_t        x;
        int          w, d;
        logic        dn, bs, e, empty;
        logic [63:0] b, s;
        w     = i ? 10 : 7;
        d     = i ? 3 : 2;
        dn    = i ? done_b : done_a;
        bs    = i ? busy_b : busy_a;
        e     = i ? en_b : en_a;
        b     = i ? 64'(bcd_b) : 64'(bcd_a);
        s     = i ? 64'(seg_b) : 64'(seg_a);
        empty = i ? (qb.size() == 0) : (qa.size() == 0);
        if (!rst_n) begin
            chk(i ? "B_rst_seg" : "A_rst_seg", s, mseg(0, d, i, 1'b0));
            chk(i ? "B_rst_bcd" : "A_rst_bcd", b, 64'd0);
            chk(i ? "B_rst_done" : "A_rst_done", 64'(dn), 64'd0);
            cur[i]  = 0;
            brun[i] = 0;
        end else begin
            chk(i ? "B_seg" : "A_seg", s, mseg(cur[i], d, i, e));
            if (bs) brun[i]++;
            if (dn) begin
                if (empty) begin
                    chk(i ? "B_done_unexpected" : "A_done_unexpected",
                        64'd1, 64'd0);
                end else begin
                    x = i ? qb.pop_front() : qa.pop_front();
                    chk(i ? "B_latency" : "A_latency", 64'(cyc), 64'(x.t));
                    chk(i ? "B_busy_len" : "A_busy_len",
                        64'(brun[i]), 64'(w + 1));
                    cur[i] = x.v;
                end
                brun[i] = 0;
            end
            chk(i ? "B_bcd" : "A_bcd", b, mbcd(cur[i], d));
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        mon(0);
        mon(1);
    end

    task automatic step(input int i, input logic ld, input int v,
                        input logic e);
        exp_t   x;
        longint t;
        int     w;
        w = i ? 10 : 7;
        t = cyc + 1;
        v = v % (1 << w);
        if (i == 0) begin
            en_a = e; load_a = ld; value_a = 7'(v);
        end else begin
            en_b = e; load_b = ld; value_b = 10'(v);
        end
        if (ld && t >= nok[i]) begin
            x.v = v;
            x.t = t + w + 1;
            if (i == 0) qa.push_back(x);
            else qb.push_back(x);
            nok[i] = t + w + 2;
        end
        @(negedge clk);
        if (i == 0) load_a = 1'b0;
        else load_b = 1'b0;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        nok[0] = 0;
        nok[1] = 0;
        #1;
        chk("A_abort_busy", 64'(busy_a), 64'd0);
        chk("A_abort_bcd", 64'(bcd_a), 64'd0);
        chk("A_abort_seg", 64'(seg_a), 64'h3fff);
        chk("A_abort_done", 64'(done_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int vals [3];
        int bvals [3];
        logic e;
        checks = 0; errors = 0; cyc = 0;
        nok[0] = 0; nok[1] = 0;
        cur[0] = 0; cur[1] = 0;
        brun[0] = 0; brun[1] = 0;
        rst_n = 1'b0;
        en_a = 1'b0; load_a = 1'b0; value_a = '0;
        en_b = 1'b0; load_b = 1'b0; value_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (2) step(0, 1'b0, 0, 1'b1);
        step(0, 1'b1, 57, 1'b1);
        repeat (10) step(0, 1'b0, 0, 1'b1);
        repeat (3) step(0, 1'b0, 0, 1'b0);
        repeat (2) step(0, 1'b0, 0, 1'b1);
        vals = '{99, 120, 127};
        foreach (vals[n]) begin
            step(0, 1'b1, vals[n], 1'b1);
            repeat (9) step(0, 1'b0, 0, 1'b1);
        end
        step(0, 1'b1, 42, 1'b1);
        repeat (3) step(0, 1'b0, 0, 1'b1);
        step(0, 1'b1, 11, 1'b1);
        repeat (8) step(0, 1'b0, 0, 1'b1);
        step(0, 1'b1, 88, 1'b1);
        repeat (4) step(0, 1'b0, 0, 1'b1);
        mid_reset();
        repeat (3) step(0, 1'b0, 0, 1'b1);

        e = 1'b1;
        repeat (300) begin
            if ($urandom_range(15) == 0) e = ~e;
            step(0, $urandom_range(3) == 0, int'($urandom_range(127)), e);
        end
        repeat (12) step(0, 1'b0, 0, 1'b1);

        repeat (2) step(1, 1'b0, 0, 1'b1);
        bvals = '{5, 0, 305};
        foreach (bvals[n]) begin
            step(1, 1'b1, bvals[n], 1'b1);
            repeat (12) step(1, 1'b0, 0, 1'b1);
        end
        e = 1'b1;
        repeat (300) begin
            if ($urandom_range(15) == 0) e = ~e;
            step(1, $urandom_range(3) == 0, int'($urandom_range(1023)), e);
        end
        repeat (20) step(1, 1'b0, 0, 1'b1);

        chk("A_pending_results", 64'(qa.size()), 64'd0);
        chk("B_pending_results", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 Parameter WIDTH, default 7, binary input width; legal 4..20.
REQ-002 Parameter DIGITS, default 2, number of decimal digits/displays; legal 1..6.
REQ-003 Parameter LZB, default 0, 1 = leading-zero blanking enabled.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  display enable; 0 = all segments dark.
REQ-007 load  input  1  request conversion of value; sampled only in IDLE.
REQ-008 value  input  WIDTH  unsigned binary number to display.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when new bcd/seg data is committed.
REQ-011 bcd  output  4*DIGITS  committed BCD result; digit k at [4k+3:4k], digit 0 = ones.
REQ-012 seg  output  7*DIGITS  active-low segments; digit k at [7k+6:7k], bit 7k+6 = a ... bit 7k = g.

Function
REQ-013 Digit encodings (a..g, MSB first) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; blank = 1111111.
REQ-014 FSM states SHALL be IDLE, CONV, COMMIT.
REQ-015 IDLE: load=1 SHALL capture value into a shift register, clear the BCD scratch register, and move to CONV; load=0 stays in IDLE.
REQ-016 CONV SHALL perform one double-dabble iteration per cycle (add 3 to every scratch digit >= 5, then shift left one bit) for exactly WIDTH cycles, then move to COMMIT.
REQ-017 COMMIT SHALL copy scratch to bcd, pulse done for that cycle, and return to IDLE.
REQ-018 busy SHALL be 1 in CONV and COMMIT, 0 in IDLE.
REQ-019 Latency: load sampled at edge t -> done=1 and new bcd visible after edge t+WIDTH+1; a new load can be accepted at edge t+WIDTH+2.
REQ-020 Saturation: if captured value > 10^DIGITS-1, committed bcd SHALL be all nines; latency unchanged.
REQ-021 load while busy=1 SHALL be ignored and not queued.
REQ-022 bcd SHALL hold its value between commits; en has no effect on bcd.
REQ-023 seg SHALL be registered: each edge, seg <= all ones if en=0, else encoding of bcd (one cycle after bcd changes or en changes).
REQ-024 With LZB=1, digits from DIGITS-1 downward SHALL be blank while they and all higher digits are 0; digit 0 is never blanked.
REQ-025 With LZB=0, all digits SHALL always display, including leading zeros.
REQ-026 Scratch digits SHALL never exceed 9 after any iteration; no BCD carry out of digit DIGITS-1 occurs for non-saturated inputs.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, bcd=0, seg=all ones, scratch and shift registers 0.
REQ-028 Reset during CONV/COMMIT SHALL abort the conversion; the pending result is discarded and done is not pulsed.
REQ-029 After rst_n deasserts, the first edge with en=1 SHALL drive seg to the encoding of bcd=0.

Verification (WIDTH=7, DIGITS=2 unless noted)
REQ-030 Reset release, en=1, no load -> after 1 edge seg = 0000001_0000001, bcd=0x00, busy=0.
REQ-031 load with value=57 -> busy high 8 cycles, done pulses once 8 edges after load, bcd=0x57, next edge seg = 0100100_0001111.
REQ-032 value=99 -> bcd=0x99; value=120 -> bcd=0x99 with identical latency; value=127 -> bcd=0x99.
REQ-033 en 1->0 with bcd=0x57 -> next edge seg=all ones, bcd stays 0x57; en->1 -> next edge seg = 0100100_0001111.
REQ-034 load pulsed again mid-conversion -> ignored, single done; rst_n low mid-conversion -> busy=0, bcd=0x00, seg=all ones, no done.
REQ-035 LZB=1, DIGITS=3, WIDTH=10: value=5 -> seg = 1111111_1111111_0100100; value=0 -> digit 0 = 0000001; value=305 -> no blanking, bcd=0x305.
